// File: rtl/schmidl_cox_pkg.sv
// Shared types and constants for the Schmidl & Cox preamble detector.
package schmidl_cox_pkg;

  // sc16 sample: I in the upper half-word, Q in the lower half-word
  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } sc16_t;

  typedef enum logic [1:0] {
    SEL_IQ_ZERO    = 2'd0,
    SEL_IQ_GATED   = 2'd1,
    SEL_METRIC_MSB = 2'd2,
    SEL_METRIC_LSB = 2'd3
  } out_sel_e;

  typedef enum logic {
    SEARCH = 1'b0,
    BURST  = 1'b1
  } fsm_e;

  localparam int          PACKET_SIZE_DEFAULT = 2304;
  localparam logic [31:0] THRESHOLD_DEFAULT   = 32'h0020_0000;
  localparam logic [1:0]  OUTPUT_SEL_DEFAULT  = 2'd0;

  // Sign-extend a 16-bit component to 33 bits so that a sum of two
  // 16x16 products is represented exactly.
  function automatic logic signed [32:0] sext33(input logic [15:0] v);
    return {{17{v[15]}}, v};
  endfunction

endpackage

// File: rtl/schmidl_cox_delay_line.sv
// L-deep shift register with push enable; dout is the word pushed DEPTH
// pushes ago (zero until DEPTH pushes have happened since reset).
module schmidl_cox_delay_line #(
  parameter int W     = 32,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] taps [DEPTH];

  // Shift one position per push; all taps cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/schmidl_cox_core.sv
// Schmidl & Cox preamble detector / burst gater on an sc16 AXI-Stream.
// Optional status outputs (o_detect, o_burst_active) are built when the
// macro SCHMIDL_COX_STATUS_EN is defined.
//
// Handshake: a transfer happens on any edge where tvalid && tready. The
// five-stage pipeline moves as a whole when advance = !m_axis_tvalid ||
// m_axis_tready, and s_axis_tready equals advance, so a sample is never
// dropped or reordered and the input is stalled only by the output.
module schmidl_cox_core
  import schmidl_cox_pkg::*;
#(
  parameter int HALF_LEN = 64,
  parameter int CNT_W    = 16
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  input  logic [CNT_W-1:0] cfg_packet_size,
  input  logic [31:0]      cfg_threshold,
  input  logic [1:0]       cfg_output_sel
`ifdef SCHMIDL_COX_STATUS_EN
  ,
  output logic             o_detect,
  output logic             o_burst_active
`endif
);

  localparam int LOG2L = $clog2(HALF_LEN);
  localparam int SH    = LOG2L + 16;       // metric scaling shift
  localparam int ACC_W = 33 + LOG2L;       // exact running-sum width
  localparam int EXT   = ACC_W - 33;
  localparam int SQ_W  = 2 * ACC_W;        // square width before saturation

  logic advance;
  assign advance       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = advance;

  // ---------------- stage 1: capture x(n) and x(n-L) ----------------
  logic        v1, last1;
  logic [31:0] x1, xd1, xd_dout;
  out_sel_e    sel1;

  schmidl_cox_delay_line #(.W(32), .DEPTH(HALF_LEN)) u_x_hist (
    .clk  (ce_clk),
    .rst  (ce_rst),
    .en   (s_axis_tvalid && advance),
    .din  (s_axis_tdata),
    .dout (xd_dout)
  );

  // Register the new sample, its delayed partner and its output selection
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      v1 <= 1'b0; last1 <= 1'b0; x1 <= '0; xd1 <= '0; sel1 <= SEL_IQ_ZERO;
    end else if (advance) begin
      v1    <= s_axis_tvalid;
      last1 <= s_axis_tlast;
      x1    <= s_axis_tdata;
      xd1   <= xd_dout;
      sel1  <= out_sel_e'(cfg_output_sel);
    end
  end

  // ---------------- stage 2: c(n) = conj(x(n-L))*x(n), e(n) = |x(n)|^2 ----------------
  sc16_t              xs, xds;
  logic signed [32:0] a_i, a_q, b_i, b_q;
  logic signed [32:0] c_re, c_im, e_now;
  logic [98:0]        ce_old;

  assign xs    = x1;
  assign xds   = xd1;
  assign a_i   = sext33(xds.i);
  assign a_q   = sext33(xds.q);
  assign b_i   = sext33(xs.i);
  assign b_q   = sext33(xs.q);
  assign c_re  = a_i * b_i + a_q * b_q;
  assign c_im  = a_i * b_q - a_q * b_i;
  assign e_now = b_i * b_i + b_q * b_q;

  schmidl_cox_delay_line #(.W(99), .DEPTH(HALF_LEN)) u_ce_hist (
    .clk  (ce_clk),
    .rst  (ce_rst),
    .en   (v1 && advance),
    .din  ({c_re, c_im, e_now}),
    .dout (ce_old)
  );

  logic               v2, last2;
  logic [31:0]        x2;
  out_sel_e           sel2;
  logic signed [32:0] c2_re, c2_im, co2_re, co2_im;
  logic [32:0]        e2, eo2;

  // Register the new correlation/energy terms next to the ones leaving the window
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      v2 <= 1'b0; last2 <= 1'b0; x2 <= '0; sel2 <= SEL_IQ_ZERO;
      c2_re <= '0; c2_im <= '0; e2 <= '0; co2_re <= '0; co2_im <= '0; eo2 <= '0;
    end else if (advance) begin
      v2     <= v1;
      last2  <= last1;
      x2     <= x1;
      sel2   <= sel1;
      c2_re  <= c_re;
      c2_im  <= c_im;
      e2     <= e_now;
      co2_re <= ce_old[98:66];
      co2_im <= ce_old[65:33];
      eo2    <= ce_old[32:0];
    end
  end

  // ---------------- stage 3: running sums P and R ----------------
  logic                    v3, last3;
  logic [31:0]             x3;
  out_sel_e                sel3;
  logic signed [ACC_W-1:0] p_re, p_im;
  logic [ACC_W-1:0]        r_acc;

  // Sliding-window sums; only real samples enter the window
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      v3 <= 1'b0; last3 <= 1'b0; x3 <= '0; sel3 <= SEL_IQ_ZERO;
      p_re <= '0; p_im <= '0; r_acc <= '0;
    end else if (advance) begin
      v3    <= v2;
      last3 <= last2;
      x3    <= x2;
      sel3  <= sel2;
      if (v2) begin
        p_re  <= p_re + {{EXT{c2_re[32]}}, c2_re} - {{EXT{co2_re[32]}}, co2_re};
        p_im  <= p_im + {{EXT{c2_im[32]}}, c2_im} - {{EXT{co2_im[32]}}, co2_im};
        r_acc <= r_acc + {{EXT{1'b0}}, e2} - {{EXT{1'b0}}, eo2};
      end
    end
  end

  // ---------------- stage 4: scaled powers ----------------
  logic signed [ACC_W-1:0] ps_re, ps_im;
  logic [ACC_W-1:0]        rs;
  logic signed [SQ_W-1:0]  ps_re_w, ps_im_w;
  logic [SQ_W-1:0]         rs_w, pow_p_full, pow_r_full;
  logic [31:0]             pow_p_sat, pow_r_sat;

  assign ps_re      = p_re >>> SH;
  assign ps_im      = p_im >>> SH;
  assign rs         = r_acc >> SH;
  assign ps_re_w    = SQ_W'(ps_re);
  assign ps_im_w    = SQ_W'(ps_im);
  assign rs_w       = SQ_W'(rs);
  assign pow_p_full = ps_re_w * ps_re_w + ps_im_w * ps_im_w;
  assign pow_r_full = rs_w * rs_w;
  assign pow_p_sat  = (|pow_p_full[SQ_W-1:32]) ? 32'hFFFF_FFFF : pow_p_full[31:0];
  assign pow_r_sat  = (|pow_r_full[SQ_W-1:32]) ? 32'hFFFF_FFFF : pow_r_full[31:0];

  logic        v4, last4;
  logic [31:0] x4, pow_p4, pow_r4;
  out_sel_e    sel4;

  // Register the saturated metrics with the sample they belong to
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      v4 <= 1'b0; last4 <= 1'b0; x4 <= '0; sel4 <= SEL_IQ_ZERO;
      pow_p4 <= '0; pow_r4 <= '0;
    end else if (advance) begin
      v4     <= v3;
      last4  <= last3;
      x4     <= x3;
      sel4   <= sel3;
      pow_p4 <= pow_p_sat;
      pow_r4 <= pow_r_sat;
    end
  end

  // ---------------- stage 5: detection, burst FSM, output ----------------
  logic [63:0] thr_prod;
  logic        detect;

  assign thr_prod = 64'(cfg_threshold) * 64'(pow_r4);
  assign detect   = (pow_r4 != 32'd0) && ({16'd0, pow_p4, 24'd0} >= {8'd0, thr_prod});

  fsm_e             state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             in_burst, burst_last, burst_first;

  // State and remaining-sample counter
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state <= SEARCH;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Burst decisions for the sample leaving stage 4; cnt counts the
  // burst samples still to come, including the current one while in BURST
  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    in_burst    = 1'b0;
    burst_last  = 1'b0;
    burst_first = 1'b0;
    if (advance && v4) begin
      case (state)
        SEARCH: begin
          if (detect && (cfg_packet_size != '0)) begin
            in_burst    = 1'b1;
            burst_first = 1'b1;
            next_cnt    = cfg_packet_size - CNT_W'(1);
            if (cfg_packet_size == CNT_W'(1)) burst_last = 1'b1;
            else                              next_state = BURST;
          end
        end
        BURST: begin
          in_burst = 1'b1;
          next_cnt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            burst_last = 1'b1;
            next_state = SEARCH;
          end
        end
        default: next_state = SEARCH;
      endcase
    end
  end

  logic [31:0] out_data;
  logic        out_valid, out_last;

  // Output word selection for the current sample
  always_comb begin
    out_data  = '0;
    out_valid = v4;
    out_last  = v4 && last4;
    case (sel4)
      SEL_IQ_ZERO:    out_data = in_burst ? x4 : 32'd0;
      SEL_IQ_GATED: begin
        out_data  = x4;
        out_valid = v4 && in_burst;
        out_last  = v4 && burst_last;
      end
      SEL_METRIC_MSB: out_data = pow_p4;
      SEL_METRIC_LSB: out_data = pow_r4;
      default:        out_data = '0;
    endcase
  end

  // Output register stage
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (advance) begin
      m_axis_tvalid <= out_valid;
      m_axis_tlast  <= out_last;
      m_axis_tdata  <= out_data;
    end
  end

`ifdef SCHMIDL_COX_STATUS_EN
  logic m_first;

  // Marks the output word that is the first sample of a burst
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst)       m_first <= 1'b0;
    else if (advance) m_first <= burst_first;
  end

  assign o_detect       = m_axis_tvalid && m_axis_tready && m_first;
  assign o_burst_active = (state == BURST);
`endif

endmodule

// File: tb/tb_schmidl_cox_core.sv
// Directed bench for schmidl_cox_core (HALF_LEN=64).
module tb_schmidl_cox_core;
  import schmidl_cox_pkg::*;

  // ---------------- clock / reset ----------------
  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [15:0] cfg_packet_size = 16'd2304;
  logic [31:0] cfg_threshold = 32'h0020_0000;
  logic [1:0]  cfg_output_sel = 2'd0;
`ifdef SCHMIDL_COX_STATUS_EN
  logic        o_detect, o_burst_active;
`endif

  always #5 ce_clk = ~ce_clk;

  schmidl_cox_core #(.HALF_LEN(64), .CNT_W(16)) dut (
    .ce_clk          (ce_clk),
    .ce_rst          (ce_rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tready   (m_axis_tready),
    .cfg_packet_size (cfg_packet_size),
    .cfg_threshold   (cfg_threshold),
    .cfg_output_sel  (cfg_output_sel)
`ifdef SCHMIDL_COX_STATUS_EN
    ,
    .o_detect        (o_detect),
    .o_burst_active  (o_burst_active)
`endif
  );

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;  // 0: always ready, 1: 75% ready, 2: never ready

  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [31:0] exp_q[$];
  logic        exp_l[$];

  // Output ready generator
  initial begin
    forever begin
      @(posedge ce_clk); #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 3) != 0);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor, sampled mid-cycle
  always @(negedge ce_clk) begin
    if (!ce_rst && m_axis_tvalid && m_axis_tready) begin
      got_d.push_back(m_axis_tdata);
      got_l.push_back(m_axis_tlast);
    end
  end

  // ---------------- reference helpers ----------------
  // Unit-magnitude-class preamble symbol, periodic in 64 samples
  function automatic logic [31:0] pat(input int j);
    int m, k;
    m = j % 64;
    k = ((m * 5) >> 1) & 3;
    case (k)
      0:       return 32'h1000_0000;
      1:       return 32'hF000_0000;
      2:       return 32'h0000_1000;
      default: return 32'h0000_F000;
    endcase
  endfunction

  // Metrics for constant x = 0x1000_0000 starting from cleared state
  function automatic logic [31:0] ref_pow_p(input int n);
    if (n < 64)  return 32'd0;
    if (n < 127) return 32'(16 * (n - 63) * (n - 63));
    return 32'h0001_0000;
  endfunction

  function automatic logic [31:0] ref_pow_r(input int n);
    if (n < 63) return 32'(16 * (n + 1) * (n + 1));
    return 32'h0001_0000;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    ready_mode    = 0;
    ce_rst        = 1'b1;
    repeat (3) @(posedge ce_clk);
    @(negedge ce_clk);
    ce_rst = 1'b0;
    got_d.delete(); got_l.delete(); exp_q.delete(); exp_l.delete();
    @(posedge ce_clk); #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input bit stall);
    int guard;
    if (stall) begin
      while ($urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge ce_clk); #1;
      end
    end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    guard = 0;
    @(negedge ce_clk);
    while (!s_axis_tready && guard < 2000) begin
      @(negedge ce_clk);
      guard++;
    end
    if (!s_axis_tready) begin
      total++; bad++;
      $display("FAIL send_ready: s_axis_tready=0 after %0d cycles, required 1", guard);
    end
    @(posedge ce_clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input string name);
    int cyc;
    cyc = 0;
    while (got_d.size() < n && cyc < 20000) begin
      @(posedge ce_clk);
      cyc++;
    end
    if (got_d.size() < n) begin
      total++; bad++;
      $display("FAIL %s_timeout: outputs=%0d required=%0d", name, got_d.size(), n);
    end
    repeat (20) @(posedge ce_clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b exp 0", m_axis_tvalid); end
    total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast: got %b exp 0", m_axis_tlast); end
    total++; if (m_axis_tdata !== 32'd0) begin bad++; $display("FAIL rst_tdata: got %h exp 0", m_axis_tdata); end
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_tready: got %b exp 1", s_axis_tready); end
    total++; if (dut.state !== SEARCH) begin bad++; $display("FAIL rst_state: got %0d exp SEARCH", dut.state); end
  endtask

  // Alternating metric selection per sample on a constant tone
  task automatic test_metrics();
    apply_reset();
    for (int n = 0; n < 140; n++) begin
      cfg_output_sel = (n % 2 == 0) ? 2'd2 : 2'd3;
      send(32'h1000_0000, 1'b0, 1'b0);
      exp_q.push_back((n % 2 == 0) ? ref_pow_p(n) : ref_pow_r(n));
    end
    wait_outputs(140, "metrics");
    total++;
    if (got_d.size() != 140) begin bad++; $display("FAIL metrics_count: got %0d exp 140", got_d.size()); end
    for (int k = 0; k < 140 && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_q[k] || got_l[k] !== 1'b0) begin
        bad++;
        $display("FAIL metrics k=%0d: got %h last=%b exp %h last=0", k, got_d[k], got_l[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_zero_input();
    apply_reset();
    cfg_output_sel = 2'd1;
    cfg_packet_size = 16'd16;
    for (int n = 0; n < 4000; n++) send(32'd0, 1'b0, 1'b0);
    repeat (20) @(posedge ce_clk);
    #1;
    total++;
    if (got_d.size() != 0) begin bad++; $display("FAIL zero_input: got %0d outputs exp 0", got_d.size()); end
    total++;
    if (dut.state !== SEARCH) begin bad++; $display("FAIL zero_state: got %0d exp SEARCH", dut.state); end
  endtask

  // Gated bursts of 16 on a steady preamble; detection first fires at j=86
  task automatic run_gated(input int nsamp, input bit stall, input string name);
    int nout;
    apply_reset();
    cfg_output_sel  = 2'd1;
    cfg_packet_size = 16'd16;
    cfg_threshold   = 32'h0020_0000;
    ready_mode      = stall ? 1 : 0;
    for (int j = 0; j < nsamp; j++) begin
      send(pat(j), 1'b0, stall);
      if (j >= 86) begin
        exp_q.push_back(pat(j));
        exp_l.push_back(((j - 86) % 16) == 15);
      end
    end
    nout = nsamp - 86;
    wait_outputs(nout, name);
    ready_mode = 0;
    repeat (10) @(posedge ce_clk);
    #1;
    total++;
    if (got_d.size() != nout) begin bad++; $display("FAIL %s_count: got %0d exp %0d", name, got_d.size(), nout); end
    for (int k = 0; k < nout && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_q[k] || got_l[k] !== exp_l[k]) begin
        bad++;
        $display("FAIL %s k=%0d: got %h last=%b exp %h last=%b", name, k, got_d[k], got_l[k], exp_q[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_gated(150, 1'b0, "burst");
  endtask

  task automatic test_stall();
    run_gated(200, 1'b1, "stall");
  endtask

  // Noise, silence, preamble, silence with zeroing outside the burst
  task automatic test_iq_zero();
    int nin;
    logic [15:0] ni, nq;
    apply_reset();
    cfg_output_sel  = 2'd0;
    cfg_packet_size = 16'd2304;
    cfg_threshold   = 32'h0020_0000;
    nin = 0;
    for (int n = 0; n < 200; n++) begin
      ni = 16'(int'($urandom_range(0, 200)) - 100);
      nq = 16'(int'($urandom_range(0, 200)) - 100);
      send({ni, nq}, 1'b0, 1'b0);
      exp_q.push_back(32'd0); exp_l.push_back(1'b0); nin++;
    end
    for (int n = 0; n < 64; n++) begin
      send(32'd0, 1'b0, 1'b0);
      exp_q.push_back(32'd0); exp_l.push_back(1'b0); nin++;
    end
    for (int j = 0; j < 2390; j++) begin
      send(pat(j), 1'b0, 1'b0);
      exp_q.push_back((j >= 86) ? pat(j) : 32'd0); exp_l.push_back(1'b0); nin++;
    end
    wait_outputs(nin, "iqzero_body");
    // keep the decaying window from retriggering after the burst
    cfg_threshold = 32'hFFFF_FFFF;
    for (int n = 0; n < 100; n++) begin
      send(32'd0, (n == 99), 1'b0);
      exp_q.push_back(32'd0); exp_l.push_back(n == 99); nin++;
    end
    wait_outputs(nin, "iqzero_tail");
    total++;
    if (got_d.size() != nin) begin bad++; $display("FAIL iqzero_count: got %0d exp %0d", got_d.size(), nin); end
    for (int k = 0; k < nin && k < got_d.size(); k++) begin
      total++;
      if (got_d[k] !== exp_q[k] || got_l[k] !== exp_l[k]) begin
        bad++;
        $display("FAIL iqzero k=%0d: got %h last=%b exp %h last=%b", k, got_d[k], got_l[k], exp_q[k], exp_l[k]);
      end
    end
    cfg_threshold = 32'h0020_0000;
  endtask

  // Reset while a burst is active and the output is stalled
  task automatic test_reset_mid();
    apply_reset();
    cfg_output_sel  = 2'd1;
    cfg_packet_size = 16'd16;
    for (int j = 0; j < 90; j++) send(pat(j), 1'b0, 1'b0);
    ready_mode = 2;
    repeat (10) @(posedge ce_clk);
    #1;
    total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL mid_pre_tvalid: got %b exp 1", m_axis_tvalid); end
    total++; if (dut.state !== BURST) begin bad++; $display("FAIL mid_pre_state: got %0d exp BURST", dut.state); end
    @(negedge ce_clk);
    ce_rst = 1'b1;
    #1;
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL mid_tvalid: got %b exp 0", m_axis_tvalid); end
    total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL mid_tlast: got %b exp 0", m_axis_tlast); end
    total++; if (dut.state !== SEARCH) begin bad++; $display("FAIL mid_state: got %0d exp SEARCH", dut.state); end
    apply_reset();
    cfg_output_sel = 2'd3;
    send(32'h1000_0000, 1'b0, 1'b0);
    send(32'h1000_0000, 1'b0, 1'b0);
    wait_outputs(2, "mid_after");
    total++;
    if (got_d.size() != 2) begin bad++; $display("FAIL mid_after_count: got %0d exp 2", got_d.size()); end
    if (got_d.size() >= 2) begin
      total++; if (got_d[0] !== 32'd16) begin bad++; $display("FAIL mid_pow_r0: got %h exp 00000010", got_d[0]); end
      total++; if (got_d[1] !== 32'd64) begin bad++; $display("FAIL mid_pow_r1: got %h exp 00000040", got_d[1]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_metrics();
    test_zero_input();
    test_back_to_back();
    test_iq_zero();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
